nvram_upload: RTL

Upload-side responder for the HPS ioctl channel: where the ROM/DIP loader consumes bytes written by the HPS, this block serves bytes the HPS reads back, used to save the game's high-score / NVRAM area to SD. It sits between `hps_io` (upload signals) and a byte-wide RAM port inside `SEGASYSTEM1`. It halts the game core for the duration of the upload, fetches each requested byte through a request/acknowledge RAM port, and stalls the HPS with `ioctl_wait` until the data is valid.

---
 rtl/sys1_pkg.sv | 31 +++
 rtl/nvram_upload.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sys1_pkg.sv
// -----------------------------------------------------------------------------
// sys1_pkg
// Shared definitions for the SEGASYSTEM1 HPS support logic.
//   - upload_state_e    : state encoding of the NVRAM upload responder
//   - UPLOAD_INDEX_DFLT : default ioctl_index that selects the NVRAM upload
//   - OOR_FILL          : byte returned for reads outside the NVRAM window
//   - addr_in_window()  : tells whether an HPS byte address is inside a
//                         2^aw byte window starting at 0
// -----------------------------------------------------------------------------
package sys1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_READY   = 3'd2,
    ST_FETCH   = 3'd3,
    ST_RELEASE = 3'd4
  } upload_state_e;

  localparam logic [7:0] UPLOAD_INDEX_DFLT = 8'd4;
  localparam logic [7:0] OOR_FILL          = 8'hFF;

  // True when every address bit at or above position aw is zero.
  function automatic logic addr_in_window(input logic [24:0] addr,
                                          input int unsigned aw);
    logic [24:0] hi_bits;
    hi_bits = addr >> aw;
    return (hi_bits == 25'd0);
  endfunction

endpackage

// File: rtl/nvram_upload.sv
// -----------------------------------------------------------------------------
// nvram_upload
// Upload-side responder for the HPS ioctl channel. While the HPS reads back
// the NVRAM / high-score area, this block halts the game core, fetches every
// requested byte through a request/acknowledge RAM port and stalls the HPS
// with ioctl_wait until the byte is valid.
//
// Ports
//   clk_sys       : system clock (48 MHz)
//   reset_n       : asynchronous active-low reset
//   ioctl_upload  : HPS upload session active
//   ioctl_index   : session index, UPLOAD_INDEX selects this block
//   ioctl_rd      : one-cycle read strobe from the HPS
//   ioctl_addr    : byte address of the read
//   ioctl_din     : byte returned to the HPS (holds between reads)
//   ioctl_wait    : HPS must hold off while high
//   pause_cpu     : core halt request
//   pause_ack     : core halted, RAM port free
//   ram_addr      : NVRAM byte address, stable while ram_req is high
//   ram_req       : fetch request, held until acknowledged
//   ram_ack       : one-cycle acknowledge, ram_q valid in the same cycle
//   ram_q         : NVRAM data
//   busy          : high whenever the responder is not idle
//   done          : one-cycle pulse when a session ends
//
// Every output is a register loaded from the next-state decode, so each
// output changes exactly on the clock that enters the corresponding state.
// -----------------------------------------------------------------------------
module nvram_upload
  import sys1_pkg::*;
#(
  parameter int unsigned AW           = 10,
  parameter logic [7:0]  UPLOAD_INDEX = UPLOAD_INDEX_DFLT
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_cpu,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_req,
  input  logic          ram_ack,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic          done
);

  upload_state_e state_r, state_s;

  // Remembers an upload drop seen while a fetch was outstanding, so the
  // session closes once the fetch completes even if ioctl_upload glitches
  // back high before ram_ack.
  logic          drop_seen_r, drop_seen_s;

  logic [7:0]    din_r, din_s;
  logic [AW-1:0] ram_addr_r, ram_addr_s;

  logic          wait_r, wait_s;
  logic          pause_r, pause_s;
  logic          req_r, req_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  logic          session_start_s;
  logic          rd_in_window_s;

  assign session_start_s = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign rd_in_window_s  = addr_in_window(ioctl_addr, AW);

  // Next-state and data-path decode.
  always_comb begin
    state_s     = state_r;
    drop_seen_s = drop_seen_r;
    din_s       = din_r;
    ram_addr_s  = ram_addr_r;

    case (state_r)
      ST_IDLE: begin
        drop_seen_s = 1'b0;
        if (session_start_s) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_HALT: begin
        // A session abandoned before the core halted still closes cleanly.
        if (!ioctl_upload) begin
          state_s = ST_RELEASE;
        end else if (pause_ack) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_HALT;
        end
      end

      ST_READY: begin
        if (!ioctl_upload) begin
          state_s = ST_RELEASE;
        end else if (ioctl_rd) begin
          if (rd_in_window_s) begin
            ram_addr_s = ioctl_addr[AW-1:0];
            state_s    = ST_FETCH;
          end else begin
            // Outside the NVRAM window: answer at once, no RAM access.
            din_s   = OOR_FILL;
            state_s = ST_READY;
          end
        end else begin
          state_s = ST_READY;
        end
      end

      ST_FETCH: begin
        if (!ioctl_upload) begin
          drop_seen_s = 1'b1;
        end else begin
          drop_seen_s = drop_seen_r;
        end

        if (ram_ack) begin
          din_s       = ram_q;
          drop_seen_s = 1'b0;
          // The outstanding fetch always completes before the session ends.
          if (drop_seen_r || !ioctl_upload) begin
            state_s = ST_RELEASE;
          end else begin
            state_s = ST_READY;
          end
        end else begin
          state_s = ST_FETCH;
        end
      end

      ST_RELEASE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s     = ST_IDLE;
        drop_seen_s = 1'b0;
      end
    endcase
  end

  // Output decode from the state being entered, registered below.
  always_comb begin
    wait_s  = 1'b0;
    pause_s = 1'b0;
    req_s   = 1'b0;
    busy_s  = 1'b1;
    done_s  = 1'b0;

    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_HALT: begin
        pause_s = 1'b1;
        wait_s  = 1'b1;
      end
      ST_READY: begin
        pause_s = 1'b1;
      end
      ST_FETCH: begin
        pause_s = 1'b1;
        wait_s  = 1'b1;
        req_s   = 1'b1;
      end
      ST_RELEASE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, data and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      drop_seen_r <= 1'b0;
      din_r       <= 8'h00;
      ram_addr_r  <= '0;
      wait_r      <= 1'b0;
      pause_r     <= 1'b0;
      req_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      drop_seen_r <= drop_seen_s;
      din_r       <= din_s;
      ram_addr_r  <= ram_addr_s;
      wait_r      <= wait_s;
      pause_r     <= pause_s;
      req_r       <= req_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign ioctl_din  = din_r;
  assign ioctl_wait = wait_r;
  assign pause_cpu  = pause_r;
  assign ram_addr   = ram_addr_r;
  assign ram_req    = req_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
